vga_capture: RTL and testbench

- Receiving end of the VGA output interface (hs, vs, 12-bit RGB). Recovers pixel column/row from the sync edges and writes each active pixel into a frame buffer write port, in the same linear layout the scan-out side reads: addr = col + row*WIDTH.
- Runs on the pixel clock (the 25 MHz divided clock).
- Used for loopback verification of the display path and for frame grab into VROM.

---
 rtl/vga_capture.sv | 158 +++++++++++++++
 tb/tb_vga_capture.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// VGA receiver: recovers column/row from hs/vs edges, checks the sync timing and
// writes active pixels into a linear frame buffer (addr = col + row*WIDTH).
module vga_capture #(
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_ACT    = 144,
  parameter int V_ACT    = 35,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cap_en,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [11:0] wr_data,
  output logic        frame_done,
  output logic        locked,
  output logic        sync_err
);

  localparam int DATA_W = 12;

  localparam logic [10:0] H_MAX    = 11'h7FF;
  localparam logic [9:0]  V_MAX    = 10'h3FF;
  localparam logic [10:0] H_LO     = 11'(H_ACT);
  localparam logic [10:0] H_HI     = 11'(H_ACT + WIDTH);
  localparam logic [10:0] H_LAST   = 11'(H_ACT + WIDTH - 1);
  localparam logic [10:0] H_TOT_M1 = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LO     = 10'(V_ACT);
  localparam logic [9:0]  V_HI     = 10'(V_ACT + HEIGHT);
  localparam logic [9:0]  V_LAST   = 10'(V_ACT + HEIGHT - 1);
  localparam logic [9:0]  V_TOT_M1 = 10'(V_TOTAL - 1);

  typedef enum logic [0:0] {
    SEARCH  = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  function automatic logic [10:0] sat_inc_h(input logic [10:0] v);
    return (v == H_MAX) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc_v(input logic [9:0] v);
    return (v == V_MAX) ? v : v + 10'd1;
  endfunction

  logic              hs_q, hs_qq, vs_q, vs_qq;
  logic [DATA_W-1:0] rgb_q, rgb_p1;
  logic [10:0]       hcnt;
  logic [9:0]        vcnt;
  logic [18:0]       addr_cnt;
  state_t            state_q, state_d;
  logic              cap_frame, skip_first;
  logic              hs_edge, vs_edge, err;
  logic              act_p1, wr_vld_p1, last_p1, last_p2, fd_d;

  // Stage q: pin registers; sync history resets to the inactive level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q  <= !SYNC_POL;
      hs_qq <= !SYNC_POL;
      vs_q  <= !SYNC_POL;
      vs_qq <= !SYNC_POL;
    end else begin
      hs_q  <= hs;
      hs_qq <= hs_q;
      vs_q  <= vs;
      vs_qq <= vs_q;
    end
  end

  always_ff @(posedge clk) begin
    rgb_q  <= {r, g, b};
    rgb_p1 <= rgb_q;
  end

  assign hs_edge = (hs_q == SYNC_POL) && (hs_qq != SYNC_POL);
  assign vs_edge = (vs_q == SYNC_POL) && (vs_qq != SYNC_POL);

  // Timing checks compare against the counts of the sample just before the edge
  always_comb begin
    state_d = state_q;
    err     = 1'b0;
    case (state_q)
      SEARCH: begin
        if (vs_edge) state_d = CAPTURE;
      end
      CAPTURE: begin
        if ((hs_edge && !skip_first && (hcnt != H_TOT_M1)) ||
            (vs_edge && (vcnt != V_TOT_M1)) ||
            (hcnt == H_MAX)) begin
          err     = 1'b1;
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Stage p1: counters, FSM and address counter describe the sample in rgb_p1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SEARCH;
      cap_frame  <= 1'b0;
      skip_first <= 1'b1;
      hcnt       <= '0;
      vcnt       <= '0;
      addr_cnt   <= '0;
    end else begin
      state_q <= state_d;
      if (vs_edge && (state_d == CAPTURE)) cap_frame <= cap_en;
      if (state_q == SEARCH)  skip_first <= 1'b1;
      else if (hs_edge)       skip_first <= 1'b0;
      hcnt <= hs_edge ? 11'd0 : sat_inc_h(hcnt);
      if (vs_edge)      vcnt <= '0;
      else if (hs_edge) vcnt <= sat_inc_v(vcnt);
      if (vs_edge)        addr_cnt <= '0;
      else if (wr_vld_p1) addr_cnt <= addr_cnt + 19'd1;
    end
  end

  assign act_p1    = (hcnt >= H_LO) && (hcnt < H_HI) && (vcnt >= V_LO) && (vcnt < V_HI);
  assign wr_vld_p1 = act_p1 && (state_q == CAPTURE) && cap_frame;
  assign last_p1   = (state_q == CAPTURE) && (hcnt == H_LAST) && (vcnt == V_LAST);
  assign fd_d      = last_p2 && (state_q == CAPTURE) && !err;

  // Stage p2: registered write port and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      last_p2    <= 1'b0;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      wr_en <= wr_vld_p1;
      if (wr_vld_p1) begin
        wr_addr <= addr_cnt;
        wr_data <= rgb_p1;
      end
      last_p2    <= last_p1;
      frame_done <= fd_d;
      sync_err   <= err;
      if (err)       locked <= 1'b0;
      else if (fd_d) locked <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture on a reduced raster: a frame-level model predicts
// write/frame_done/sync_err events, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_vga_capture;

  localparam int WIDTH   = 6;
  localparam int HEIGHT  = 3;
  localparam int H_TOTAL = 16;
  localparam int V_TOTAL = 7;
  localparam int H_ACT   = 4;
  localparam int V_ACT   = 2;
  localparam int HS_LEN  = 2;
  localparam int VS_LEN  = 2;
  localparam int EV_WR   = 0;
  localparam int EV_FD   = 1;
  localparam int EV_ERR  = 2;

  typedef struct {
    int          kind;
    logic [18:0] addr;
    logic [11:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cap_en;
  logic        hs_i, vs_i;
  logic [3:0]  r_i, g_i, b_i;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [11:0] wr_data;
  logic        frame_done, locked, sync_err;

  int          total = 0;
  int          bad   = 0;
  ev_t         exp_q[$];
  logic [11:0] pix [V_TOTAL][H_TOTAL];
  bit          model_capture = 1'b0;
  bit          model_locked  = 1'b0;
  longint      fs_time = 0;
  bit          lat_armed = 1'b0;
  logic [18:0] last_addr = '0;
  logic [11:0] last_data = '0;

  always #5 clk = ~clk;

  vga_capture #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .H_ACT(H_ACT), .V_ACT(V_ACT), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .hs(hs_i), .vs(vs_i),
    .r(r_i), .g(g_i), .b(b_i),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .locked(locked), .sync_err(sync_err)
  );

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input int kind, input int addr, input logic [11:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = 19'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic take_ev(input int kind, input logic [18:0] a, input logic [11:0] d);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
      return;
    end
    total--;
    e = exp_q.pop_front();
    check("event_kind", kind, e.kind);
    if (kind == EV_WR && e.kind == EV_WR) begin
      check("wr_addr", a, e.addr);
      check("wr_data", d, e.data);
    end
  endtask

  // Monitor: sample between active edges and compare against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      last_addr = '0;
      last_data = '0;
    end else begin
      if (wr_en) begin
        take_ev(EV_WR, wr_addr, wr_data);
        if (lat_armed) begin
          check("first_wr_latency", (longint'($time) - 5 - fs_time) / 10,
                V_ACT * H_TOTAL + H_ACT + 2);
          check("first_wr_addr", wr_addr, 0);
          lat_armed = 1'b0;
        end
        last_addr = wr_addr;
        last_data = wr_data;
      end else begin
        check("hold_addr", wr_addr, last_addr);
        check("hold_data", wr_data, last_data);
      end
      if (frame_done) take_ev(EV_FD, '0, '0);
      if (sync_err)   take_ev(EV_ERR, '0, '0);
    end
  end

  task automatic drive(input logic h, input logic v, input logic [11:0] px);
    @(posedge clk);
    #1;
    hs_i = h;
    vs_i = v;
    {r_i, g_i, b_i} = px;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    check("wr_en_before_rst", wr_en, 1);
    rst = 1'b1;
    exp_q.delete();
    model_capture = 1'b0;
    model_locked  = 1'b0;
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_locked", locked, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One frame: the model predicts the events from the frame's shape, then it is driven.
  // bad_line is one clock short; stuck_line never starts (hs held inactive).
  task automatic run_frame(input bit cap, input bit ramp, input int bad_line,
                           input int stuck_line, input int rst_line, input int rst_col);
    bit stop    = 1'b0;
    bit any_wr  = 1'b0;
    bit entered = !model_capture;
    int len;
    for (int l = 0; l < V_TOTAL; l++)
      for (int c = 0; c < H_TOTAL; c++)
        pix[l][c] = ramp ? 12'(c) : 12'($urandom);
    model_capture = 1'b1;
    for (int l = 0; l < V_TOTAL && !stop; l++) begin
      if (l == stuck_line) begin
        push_ev(EV_ERR, 0, '0);
        model_capture = 1'b0;
        model_locked  = 1'b0;
        stop = 1'b1;
      end else begin
        if (cap && l >= V_ACT && l < V_ACT + HEIGHT)
          for (int c = H_ACT; c < H_ACT + WIDTH; c++) begin
            push_ev(EV_WR, (l - V_ACT) * WIDTH + (c - H_ACT), pix[l][c]);
            any_wr = 1'b1;
          end
        if (l == V_ACT + HEIGHT - 1) begin
          push_ev(EV_FD, 0, '0);
          model_locked = 1'b1;
        end
        if (l == bad_line && !(entered && l == 0)) begin
          push_ev(EV_ERR, 0, '0);
          model_capture = 1'b0;
          model_locked  = 1'b0;
          stop = 1'b1;
        end
      end
    end

    cap_en = cap;
    for (int l = 0; l < V_TOTAL; l++) begin
      if (l == stuck_line) begin
        repeat (2100) drive(1'b1, 1'b1, 12'($urandom));
        break;
      end
      if (!cap && l == 3) cap_en = 1'b1;
      len = (l == bad_line) ? H_TOTAL - 1 : H_TOTAL;
      for (int c = 0; c < len; c++) begin
        drive((c < HS_LEN) ? 1'b0 : 1'b1, (l < VS_LEN) ? 1'b0 : 1'b1, pix[l][c]);
        if (l == 0 && c == 0) begin
          fs_time   = longint'($time) + 9;
          lat_armed = any_wr;
        end
        if (l == rst_line && c == rst_col) do_reset();
      end
    end
    check("locked_after_frame", locked, model_locked);
  endtask

  initial begin
    rst    = 1'b1;
    cap_en = 1'b0;
    hs_i   = 1'b1;
    vs_i   = 1'b1;
    {r_i, g_i, b_i} = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_wr_en", wr_en, 0);
    check("reset_wr_addr", wr_addr, 0);
    check("reset_wr_data", wr_data, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_locked", locked, 0);
    check("reset_sync_err", sync_err, 0);
    rst = 1'b0;
    repeat (5) drive(1'b1, 1'b1, '0);

    run_frame(1'b1, 1'b1, -1, -1, -1, -1);   // ramp pattern, first lock
    run_frame(1'b1, 1'b0, -1, -1, -1, -1);
    run_frame(1'b1, 1'b0, V_ACT, -1, -1, -1); // short line mid-frame
    run_frame(1'b1, 1'b0, -1, -1, -1, -1);   // relock
    run_frame(1'b0, 1'b0, -1, -1, -1, -1);   // capture off at frame start
    run_frame(1'b1, 1'b0, -1, -1, -1, -1);
    run_frame(1'b1, 1'b0, -1, 4, -1, -1);    // hs stuck inactive
    run_frame(1'b1, 1'b0, -1, -1, -1, -1);
    run_frame(1'b1, 1'b0, -1, -1, 3, 7);     // reset during writes
    run_frame(1'b1, 1'b0, -1, -1, -1, -1);

    repeat (20) drive(1'b1, 1'b1, '0);
    check("queue_empty", exp_q.size(), 0);
    check("final_locked", locked, model_locked);
    check("final_sync_err", sync_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
